// File: rtl/nonce_result_arbiter.sv
// Holds one golden nonce per slave and arbitrates them round-robin onto the shared serial uplink.
// Latency: a strobe in cycle t appears on tx_send/tx_word in cycle t+2 when the uplink is idle.
// Backpressure: one grant in flight; tx_busy stalls grants, and a repeat strobe on a full slot is dropped and counted.
module nonce_result_arbiter #(
    parameter int SLAVES      = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SLAVES*32-1:0] slave_nonces,
    input  logic [SLAVES-1:0]    new_nonces,
    input  logic                 tx_busy,
    output logic                 tx_send,
    output logic [31:0]          tx_word,
    output logic [SLAVES-1:0]    pending,
    output logic [15:0]          drop_count,
    output logic [7:0]           timeout_count
);
    localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [TW-1:0]   ack_timer;
    logic [31:0]     hold [SLAVES];

    logic            hi_vld;
    logic [PW-1:0]   hi_idx;
    logic            lo_vld;
    logic [PW-1:0]   lo_idx;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [SLAVES-1:0] grant_vec;
    logic [SLAVES-1:0] drop_vec;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_next;

    // Round-robin pick: lowest pending index above the pointer, else lowest at or below it (wrap).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (i > int'(rr_ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = PW'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = PW'(i);
                end
            end
        end
        grant_vld = (state == IDLE) && !tx_busy && (hi_vld || lo_vld);
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Per-slot grant and drop decode; drops in one cycle are summed then saturated.
    always_comb begin
        grant_vec = '0;
        drop_vec  = '0;
        drop_sum  = {1'b0, drop_count};
        for (int i = 0; i < SLAVES; i++) begin
            grant_vec[i] = grant_vld && (grant_idx == PW'(i));
            drop_vec[i]  = new_nonces[i] && pending[i] && !grant_vec[i];
            drop_sum     = drop_sum + {16'd0, drop_vec[i]};
        end
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Holding registers: accept a strobe into a free slot or into the slot being granted right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            drop_count <= '0;
            for (int i = 0; i < SLAVES; i++) begin
                hold[i] <= '0;
            end
        end else begin
            drop_count <= drop_next;
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i] && (!pending[i] || grant_vec[i])) begin
                    hold[i]    <= slave_nonces[i*32 +: 32];
                    pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Uplink handshake: pulse send once per grant, wait for busy to rise then fall, or give up after the ack window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= PW'(SLAVES - 1);
            ack_timer     <= '0;
            tx_send       <= 1'b0;
            tx_word       <= '0;
            timeout_count <= '0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        tx_send   <= 1'b1;
                        tx_word   <= hold[grant_idx];
                        rr_ptr    <= grant_idx;
                        ack_timer <= '0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_timer == TW'(ACK_TIMEOUT)) begin
                        // The word is considered sent; it is not retried.
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        ack_timer <= ack_timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Bench for nonce_result_arbiter: directed scenarios plus random strobes against a slot/uplink reference model.
// Latency: outputs compared every cycle on the falling edge, one cycle after the inputs were applied.
// Backpressure: a transmitter model raises busy after each send (or never, or forced) to exercise stalls and timeouts.
module tb_nonce_result_arbiter;
    localparam int SLAVES      = 4;
    localparam int ACK_TIMEOUT = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [SLAVES*32-1:0] slave_nonces;
    logic [SLAVES-1:0]    new_nonces;
    logic                 tx_busy;
    logic                 tx_send;
    logic [31:0]          tx_word;
    logic [SLAVES-1:0]    pending;
    logic [15:0]          drop_count;
    logic [7:0]           timeout_count;

    always #5 clk = ~clk;

    nonce_result_arbiter #(
        .SLAVES      (SLAVES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .slave_nonces  (slave_nonces),
        .new_nonces    (new_nonces),
        .tx_busy       (tx_busy),
        .tx_send       (tx_send),
        .tx_word       (tx_word),
        .pending       (pending),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // transmitter model state
    bit force_busy = 1'b0;
    bit never_ack  = 1'b0;
    int busy_len   = 10;
    int busy_left  = 0;

    logic [31:0] sent_q [$];

    // reference model: one slot per slave plus the state of the single uplink
    bit          m_pend [SLAVES];
    logic [31:0] m_hold [SLAVES];
    int          m_ptr;
    int          m_link;     // 0 free, 1 awaiting ack, 2 transmitter busy
    int          m_ack_by;
    int          m_edge;
    logic        m_send;
    logic [31:0] m_word;
    int          m_drops;
    int          m_touts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SLAVES-1:0] m_pend_vec();
        logic [SLAVES-1:0] v;
        v = '0;
        for (int i = 0; i < SLAVES; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [SLAVES*32-1:0] nv1(input int idx, input logic [31:0] val);
        logic [SLAVES*32-1:0] v;
        v = '0;
        v[idx*32 +: 32] = val;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLAVES; i++) begin
            m_pend[i] = 1'b0;
            m_hold[i] = '0;
        end
        m_ptr    = SLAVES - 1;
        m_link   = 0;
        m_ack_by = 0;
        m_edge   = 0;
        m_send   = 1'b0;
        m_word   = '0;
        m_drops  = 0;
        m_touts  = 0;
    endtask

    // advance the model across one rising edge using the inputs applied before it
    task automatic model_step(input logic [SLAVES-1:0] nn, input logic [SLAVES*32-1:0] nv, input logic busy);
        int g;
        g = -1;
        m_edge++;
        if (m_link == 0 && !busy) begin
            for (int k = 1; k <= SLAVES; k++) begin
                int j = (m_ptr + k) % SLAVES;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        m_send = (g >= 0);
        if (g >= 0) begin
            m_word   = m_hold[g];
            m_ptr    = g;
            m_link   = 1;
            m_ack_by = m_edge + ACK_TIMEOUT + 1;
        end else if (m_link == 1) begin
            if (busy) m_link = 2;
            else if (m_edge == m_ack_by) begin
                m_link = 0;
                if (m_touts < 255) m_touts++;
            end
        end else if (m_link == 2 && !busy) begin
            m_link = 0;
        end
        for (int i = 0; i < SLAVES; i++) begin
            if (nn[i]) begin
                if (!m_pend[i] || i == g) begin
                    m_hold[i] = nv[i*32 +: 32];
                    m_pend[i] = 1'b1;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end else if (i == g) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("tx_send", 32'(tx_send), 32'(m_send));
        check("tx_word", tx_word, m_word);
        check("pending", 32'(pending), 32'(m_pend_vec()));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("timeout_count", 32'(timeout_count), 32'(m_touts));
    endtask

    // one clock cycle: apply inputs, step model, react as the transmitter, compare on the falling edge
    task automatic tick(input logic [SLAVES-1:0] nn, input logic [SLAVES*32-1:0] nv);
        logic sent;
        new_nonces   = nn;
        slave_nonces = nv;
        tx_busy      = force_busy || (busy_left > 0);
        sent         = tx_send;
        model_step(nn, nv, tx_busy);
        @(posedge clk);
        if (busy_left > 0) busy_left--;
        if (sent && !never_ack) busy_left = busy_len;
        @(negedge clk);
        new_nonces = '0;
        compare_all();
        if (tx_send) sent_q.push_back(tx_word);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 400 && !(m_link == 0 && m_pend_vec() == '0 && busy_left == 0)) begin
            tick('0, '0);
            k++;
        end
        check("drain_done", 32'(k < 400), 32'd1);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        new_nonces   = '0;
        slave_nonces = '0;
        tx_busy      = 1'b0;
        force_busy   = 1'b0;
        never_ack    = 1'b0;
        busy_left    = 0;
        busy_len     = 10;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sent_q.delete();
        compare_all();
    endtask

    initial begin
        rst_n        = 1'b0;
        new_nonces   = '0;
        slave_nonces = '0;
        tx_busy      = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_timeout", 32'(timeout_count), 32'd0);

        // single nonce, send at strobe+2
        tick(4'b0001, nv1(0, 32'hDEADBEEF));
        check("single_t1_send", 32'(tx_send), 32'd0);
        check("single_t1_pend", 32'(pending), 32'd1);
        tick('0, '0);
        check("single_t2_send", 32'(tx_send), 32'd1);
        check("single_word", tx_word, 32'hDEADBEEF);
        check("single_pend_clear", 32'(pending), 32'd0);
        drain();
        check("single_pulses", 32'(sent_q.size()), 32'd1);

        // round-robin fairness
        do_reset();
        tick(4'b1111, {32'h3, 32'h2, 32'h1, 32'h0});
        drain();
        check("rr_count", 32'(sent_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < sent_q.size()) check("rr_order", sent_q[i], 32'(i));
        end
        sent_q.delete();
        tick(4'b1001, {32'h33, 32'h0, 32'h0, 32'h30});
        drain();
        check("rr_wrap_count", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) begin
            check("rr_wrap_first", sent_q[0], 32'h30);
            check("rr_wrap_second", sent_q[1], 32'h33);
        end

        // drop while uplink busy
        do_reset();
        force_busy = 1'b1;
        tick(4'b0010, nv1(1, 32'hA));
        tick('0, '0);
        tick(4'b0010, nv1(1, 32'hB));
        check("drop_count_now", 32'(drop_count), 32'd1);
        force_busy = 1'b0;
        drain();
        check("drop_sent_count", 32'(sent_q.size()), 32'd1);
        if (sent_q.size() >= 1) check("drop_kept_old", sent_q[0], 32'hA);
        check("drop_count_final", 32'(drop_count), 32'd1);

        // same-cycle regrant
        do_reset();
        tick(4'b0001, nv1(0, 32'h4));
        tick(4'b0001, nv1(0, 32'h5));
        check("regrant_send", 32'(tx_send), 32'd1);
        check("regrant_word", tx_word, 32'h4);
        check("regrant_pend", 32'(pending), 32'd1);
        drain();
        check("regrant_count", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) begin
            check("regrant_first", sent_q[0], 32'h4);
            check("regrant_second", sent_q[1], 32'h5);
        end
        check("regrant_drops", 32'(drop_count), 32'd0);

        // ack timeout
        do_reset();
        never_ack = 1'b1;
        tick(4'b0101, {32'h0, 32'h22, 32'h0, 32'h11});
        tick('0, '0);
        check("to_send1", 32'(tx_send), 32'd1);
        check("to_word1", tx_word, 32'h11);
        repeat (ACK_TIMEOUT) tick('0, '0);
        check("to_before", 32'(timeout_count), 32'd0);
        check("to_quiet", 32'(sent_q.size()), 32'd1);
        tick('0, '0);
        check("to_count", 32'(timeout_count), 32'd1);
        tick('0, '0);
        check("to_send2", 32'(tx_send), 32'd1);
        check("to_word2", tx_word, 32'h22);
        drain();
        check("to_count2", 32'(timeout_count), 32'd2);

        // async reset in the middle of a transfer with two slots pending
        do_reset();
        tick(4'b0001, nv1(0, 32'h70));
        tick('0, '0);
        tick(4'b0110, {32'h0, 32'h72, 32'h71, 32'h0});
        tick('0, '0);
        tick('0, '0);
        check("ar_pend_before", 32'(pending), 32'h6);
        check("ar_word_before", tx_word, 32'h70);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tx_send", 32'(tx_send), 32'd0);
        check("ar_tx_word", tx_word, 32'd0);
        check("ar_pending", 32'(pending), 32'd0);
        check("ar_drop", 32'(drop_count), 32'd0);
        check("ar_timeout", 32'(timeout_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sent_q.delete();
        repeat (20) tick('0, '0);
        check("ar_no_send", 32'(sent_q.size()), 32'd0);
        tick(4'b1000, nv1(3, 32'h99));
        drain();
        check("ar_new_count", 32'(sent_q.size()), 32'd1);
        if (sent_q.size() == 1) check("ar_new_word", sent_q[0], 32'h99);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [SLAVES-1:0]    nn;
            logic [SLAVES*32-1:0] nv;
            for (int i = 0; i < SLAVES; i++) begin
                nn[i]          = ($urandom_range(0, 5) == 0);
                nv[i*32 +: 32] = $urandom;
            end
            if ((c % 500) == 250) never_ack = ~never_ack;
            force_busy = ($urandom_range(0, 15) == 0);
            busy_len   = $urandom_range(1, 6);
            tick(nn, nv);
        end
        force_busy = 1'b0;
        never_ack  = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nonce_result_arbiter.md
Name: nonce_result_arbiter

Overview:
Parameterised collector and arbiter sitting between the per-slave slave_receive outputs in the hub and the single shared serial_transmit uplink. It holds one pending golden nonce per slave and grants the uplink round-robin. It runs a send/busy handshake that never re-issues a word before the transmitter has acknowledged the previous one. It also counts nonces lost to back-to-back arrivals.

Parameters:
SLAVES, 2, number of result sources (local miners plus external ports); must be at least 1.
ACK_TIMEOUT, 15, cycles to wait for tx_busy to rise after a send pulse before abandoning the handshake; must be at least 1.

Ports:
clk  input  1  hash clock, rising-edge
rst_n  input  1  asynchronous active-low reset
slave_nonces  input  SLAVES*32  nonce from slave i on bits [i*32+31:i*32]
new_nonces  input  SLAVES  one-cycle strobe per slave; the nonce is valid in the same cycle
tx_busy  input  1  busy output of serial_transmit
tx_send  output  1  one-cycle send pulse to serial_transmit
tx_word  output  32  word to transmit; held stable from the send pulse until return to IDLE
pending  output  SLAVES  per-slave holding-register-full flags
drop_count  output  16  saturating count of discarded nonces
timeout_count  output  8  saturating count of ACK timeouts

Behaviour:
- One clock and one reset: clk, asynchronous active-low rst_n. All state is cleared on reset assertion without waiting for a clock edge.
- Reset values: tx_send=0, tx_word=0, pending=0, drop_count=0, timeout_count=0, FSM=IDLE, round-robin pointer=SLAVES-1, so slave 0 has first priority.
- Capture, every cycle, for each slave i:
  - If new_nonces[i]=1 and the slot is free, or the slot is being granted in this same cycle: hold[i]<=nonce and pending[i]<=1.
  - If new_nonces[i]=1 and pending[i]=1 and slot i is not being granted this cycle: keep the held (older) nonce, discard the new one, and increment drop_count by 1.
  - Several drops in one cycle add their count in one step; the result saturates at 16'hFFFF.
- Arbitration happens in IDLE only:
  - If tx_busy=0 and |pending: grant g = first pending index scanning from pointer+1 upward, wrapping modulo SLAVES.
  - On a grant: tx_word<=hold[g], pending[g]<=0 (unless re-captured in the same cycle), pointer<=g, tx_send<=1, go to WAIT_ACK.
  - If tx_busy=1 in IDLE, no grant is made.
- FSM states:
  - IDLE: as above.
  - WAIT_ACK: tx_send=0. Timer counts up from 0.
    - tx_busy=1 -> WAIT_DONE.
    - Timer reaches ACK_TIMEOUT with tx_busy still 0 -> timeout_count+1 (saturating at 8'hFF) -> IDLE. The word is treated as sent and is not retried.
  - WAIT_DONE: on tx_busy=0 -> IDLE.
- tx_send is high for exactly one cycle per grant. At most one grant is in flight at any time.
- Latency: strobe in cycle t, transmitter idle and no other pending slots -> tx_send=1 in cycle t+2 with tx_word equal to the strobed nonce.
- Earliest next grant: the cycle after the FSM returns to IDLE.
- SLAVES=1: the pointer is constant and the block degenerates to a single-slot buffer.
- Reset mid-handshake: everything returns to reset values. Pending nonces are lost and not counted as drops.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Single nonce: slave 0 strobes 32'hDEADBEEF, transmitter model raises busy 1 cycle after send and holds it 10 cycles -> exactly one tx_send pulse at strobe+2, tx_word=32'hDEADBEEF, pending returns to 0, no second pulse.
- Round-robin fairness: SLAVES=4, all four strobe simultaneously with values 32'h0 to 32'h3 -> words sent in order 0,1,2,3. Then slaves 3 and 0 strobe together -> 0 is sent before 3 (pointer at 3).
- Drop: slave 1 strobes 32'hA while the uplink is busy, then strobes 32'hB two cycles later -> 32'hA is sent, 32'hB is never sent, drop_count=1.
- Same-cycle regrant: slave 0 strobes 32'h5 in the very cycle its slot 32'h4 is granted -> 32'h4 is sent, then 32'h5 is sent, drop_count=0.
- ACK timeout: transmitter model never raises busy -> tx_send pulses once, timeout_count=1 after ACK_TIMEOUT+1 cycles, and the next pending word is sent afterwards.
- Async reset: assert rst_n=0 mid-WAIT_DONE with two slots pending -> all outputs are 0 immediately without a clock edge. After release, no tx_send occurs until a new strobe arrives.
